// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, warms it up, then counts
// synchronized rising edges of osc_in over a programmable window of clk cycles.
module ro_freq_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned GATE_W   = 16,
    parameter int unsigned WARM_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              osc_in,
    output logic              ro_enable,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int unsigned WarmW = $clog2(WARM_CYC) + 1;
    localparam logic [WarmW-1:0] WarmLast = WarmW'(WARM_CYC - 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StWarmup, StMeasure, StDone} state_e;

    state_e            state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [WarmW-1:0]  warm_q, warm_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              s1_q, s2_q, s3_q;
    logic              rise;

    // s3 only holds history; s1/s2 resolve metastability of the async oscillator.
    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        warm_d  = warm_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gate_d  = gate_cycles;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    warm_d  = '0;
                    state_d = StWarmup;
                end
            end
            StWarmup: begin
                warm_d = warm_q + WarmW'(1);
                if (warm_q == WarmLast) begin
                    state_d = (gate_q == '0) ? StDone : StMeasure;
                end
            end
            StMeasure: begin
                gate_d = gate_q - GATE_W'(1);
                if (rise) begin
                    if (count_q == CntMax) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                if (gate_q == GATE_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gate_q  <= '0;
            warm_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            warm_q  <= warm_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            s1_q    <= osc_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
        end
    end

    assign busy      = (state_q == StWarmup) || (state_q == StMeasure);
    assign ro_enable = busy;
    assign done      = (state_q == StDone);
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a default instance and a CNT_W=4 instance for saturation.
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] gate_cycles = '0;
    logic        osc = 1'b0;
    logic        ro_enable_a, busy_a, done_a, overflow_a;
    logic        ro_enable_b, busy_b, done_b, overflow_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;

    int n_checks = 0;
    int n_fail   = 0;
    int osc_half = 0;
    logic osc_level = 1'b0;
    int ph = 0;

    ro_freq_meter dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .gate_cycles(gate_cycles),
        .osc_in     (osc),
        .ro_enable  (ro_enable_a),
        .busy       (busy_a),
        .done       (done_a),
        .count      (count_a),
        .overflow   (overflow_a)
    );

    ro_freq_meter #(.CNT_W(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .gate_cycles(gate_cycles),
        .osc_in     (osc),
        .ro_enable  (ro_enable_b),
        .busy       (busy_b),
        .done       (done_b),
        .count      (count_b),
        .overflow   (overflow_b)
    );

    always #5 clk = ~clk;

    // Oscillator model: toggles every osc_half clk cycles, or holds osc_level when 0.
    always @(negedge clk) begin
        if (osc_half == 0) begin
            osc = osc_level;
        end else begin
            ph = ph + 1;
            if (ph >= osc_half) begin
                ph  = 0;
                osc = ~osc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts dut_a and returns the cycle (relative to the start edge) where done is seen.
    task automatic measure(input logic [15:0] g, output int lat, output int busy_n);
        gate_cycles = g;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 1;
        busy_n = 0;
        while (!done_a && lat < 1000) begin
            if (busy_a) busy_n++;
            tick();
            lat++;
        end
    endtask

    int lat, busy_n, done_cnt, done_at, bad;
    logic [3:0] prev_b;
    logic wrapped;

    initial begin
        // Reset with start high and oscillator toggling.
        osc_half = 1;
        start_a = 1'b1;
        start_b = 1'b1;
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ro_enable_a || busy_a || done_a || overflow_a || count_a != 0) bad++;
            if (ro_enable_b || busy_b || done_b || overflow_b || count_b != 0) bad++;
        end
        check("reset_outputs_zero", bad, 0);
        check("reset_ro_enable", ro_enable_a, 0);
        start_a = 1'b0;
        start_b = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_busy", busy_a, 0);

        // Nominal: period 4, gate 100 -> 25 edges, done at +109.
        osc_half = 2;
        measure(16'd100, lat, busy_n);
        check("nominal_latency", lat, 109);
        check("nominal_count", count_a, 25);
        check("nominal_overflow", overflow_a, 0);
        check("nominal_busy_cycles", busy_n, 108);
        tick();
        check("done_is_pulse", done_a, 0);
        check("count_holds", count_a, 25);
        check("ro_enable_off_idle", ro_enable_a, 0);

        // Zero gate.
        measure(16'd0, lat, busy_n);
        check("zero_latency", lat, 9);
        check("zero_count", count_a, 0);
        check("zero_busy_cycles", busy_n, 8);
        tick();

        // Saturation on the 4-bit instance: period 2, gate 40 -> 20 edges.
        osc_half = 1;
        gate_cycles = 16'd40;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat = 1;
        wrapped = 1'b0;
        prev_b = count_b;
        while (!done_b && lat < 1000) begin
            if (count_b < prev_b) wrapped = 1'b1;
            prev_b = count_b;
            tick();
            lat++;
        end
        check("sat_latency", lat, 49);
        check("sat_count", count_b, 15);
        check("sat_overflow", overflow_b, 1);
        check("sat_no_wrap", wrapped, 0);
        tick();

        // Protocol: start in WARMUP, MEASURE and on the done cycle are ignored.
        osc_half = 2;
        gate_cycles = 16'd20;
        start_a = 1'b1;
        tick();
        done_cnt = 0;
        done_at = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done_a) begin
                done_cnt++;
                done_at = n;
            end
            start_a = (n == 3) || (n == 15) || done_a;
            gate_cycles = 16'(n);
            tick();
        end
        start_a = 1'b0;
        check("proto_done_count", done_cnt, 1);
        check("proto_done_at", done_at, 29);
        check("proto_idle_after", busy_a, 0);
        check("proto_count", count_a, 5);
        measure(16'd4, lat, busy_n);
        check("proto_restart_latency", lat, 13);
        tick();

        // Stuck-high oscillator.
        osc_half = 0;
        osc_level = 1'b1;
        tick();
        tick();
        measure(16'd50, lat, busy_n);
        check("stuck_latency", lat, 59);
        check("stuck_count", count_a, 0);
        tick();

        // Reset 10 cycles into MEASURE.
        osc_half = 2;
        gate_cycles = 16'd50;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 1; n < 19; n++) tick();
        check("midrst_measuring", busy_a, 1);
        check("midrst_count_nonzero", (count_a != 0), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy_a, 0);
        check("midrst_ro_enable", ro_enable_a, 0);
        check("midrst_count", count_a, 0);
        check("midrst_done", done_a, 0);
        done_cnt = 0;
        for (int n = 0; n < 80; n++) begin
            if (done_a) done_cnt++;
            tick();
        end
        check("midrst_no_done", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
